// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, S-box lookup and key-schedule helper
//
// Purpose : common definitions for the AES encryption datapath stages.
//           DW      state/key width (fixed at 128)
//           NR      number of rounds for AES-128
//           sbox()  forward S-box byte lookup (also used by subBytesE)
//           rcon()  round constant lookup, index clamped to the last entry
//           expand_key() one key-schedule step given SubWord(RotWord(w3))
package aes_pkg;

    localparam int DW = 128;
    localparam int NR = 10;

    typedef enum logic {
        ARK_IDLE,
        ARK_RUN
    } ark_state_t;

    // Row 0 of the S-box sits in the most significant bits.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Rcon[0] in the most significant byte.
    localparam logic [79:0] RCON_FLAT = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[(255 - int'(x)) * 8 +: 8];
    endfunction

    // Indices past the table only occur for the unused expansion after the
    // final round, so clamping keeps the lookup in range without affecting
    // any visible result.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        int i;
        i = (idx > 4'd9) ? 9 : int'(idx);
        return RCON_FLAT[(9 - i) * 8 +: 8];
    endfunction

    // sw is SubWord(RotWord(w3)) of rk; w0 is the most significant word.
    function automatic logic [DW-1:0] expand_key(input logic [DW-1:0] rk,
                                                 input logic [31:0]   sw,
                                                 input logic [7:0]    rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sw ^ {rc, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/sub_word_e.sv
// rtl/sub_word_e.sv - 32-bit AES SubWord built from four S-box lookups
//
// Purpose : byte-wise S-box substitution of one key-schedule word.
// Ports   : word   in  32  word to substitute
//           result out 32  S-box applied to each byte, byte order kept
module sub_word_e
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    assign result = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/add_round_key_e.sv
// rtl/add_round_key_e.sv - sequential AES-128 AddRoundKey with on-the-fly key schedule
//
// Purpose : XORs each accepted round state with the current round key and
//           registers the result; derives the next round key per accept.
// Ports   : clk        in   1    rising-edge clock
//           reset      in   1    asynchronous active-high reset
//           Key        in   128  cipher key, sampled on a round-0 accept
//           Input      in   128  round state from upstream
//           in_valid   in   1    Input valid
//           in_ready   out  1    block can accept Input
//           Output     out  128  Input ^ round key, registered
//           out_valid  out  1    Output valid
//           out_ready  in   1    downstream accepts Output
//           Round      out  4    round index (0..NR) of the result in Output
//           done       out  1    one-cycle pulse when round NR is consumed
module add_round_key_e
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] Key,
    input  logic [DW-1:0] Input,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] Output,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    Round,
    output logic          done
);

    ark_state_t    state;
    logic [DW-1:0] key_reg;
    logic [DW-1:0] rk_cur;
    logic [DW-1:0] rk_next;
    logic [31:0]   sw_out;
    logic [3:0]    rcon_idx;
    logic          accept;
    logic          out_fire;

    // Only registered terms feed in_ready, so out_ready never reaches it
    // combinationally; a result must drain before the next round enters.
    assign in_ready = (state == ARK_IDLE) || !out_valid;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        rk_cur   = key_reg;
        rcon_idx = Round + 4'd1;
        if (state == ARK_IDLE) begin
            rk_cur   = Key;
            rcon_idx = 4'd0;
        end
    end

    sub_word_e u_sub_word (
        .word   ({rk_cur[23:0], rk_cur[31:24]}),
        .result (sw_out)
    );

    assign rk_next = expand_key(rk_cur, sw_out, rcon(rcon_idx));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARK_IDLE;
            key_reg   <= '0;
            Output    <= '0;
            out_valid <= 1'b0;
            Round     <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                Output    <= Input ^ rk_cur;
                out_valid <= 1'b1;
                key_reg   <= rk_next;
                if (state == ARK_IDLE) begin
                    Round <= 4'd0;
                    state <= ARK_RUN;
                end else if (Round < 4'(NR)) begin
                    Round <= Round + 4'd1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                if (Round == 4'(NR)) begin
                    state <= ARK_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule
